committed_rename_table: RTL and testbench

Parametrised architectural-state rename table in the Commit stage. It holds the committed ARF→PRF mapping, updated by up to COMMIT_WIDTH retiring instructions per cycle. On every commit it returns the superseded physical register to the free list. On a pipeline flush it streams the committed map, a group of entries per cycle, into the front-end speculative RAT for recovery.

---
 rtl/falco_pkg.sv | 17 +
 rtl/crt_bypass_resolve.sv | 30 +++
 rtl/committed_rename_table.sv | 130 +++++++++++++
 tb/tb_committed_rename_table.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/falco_pkg.sv
// rtl/falco_pkg.sv - shared types and defaults for the committed rename table
package Falco_pkg;

  localparam int ARF_NUM_DEFAULT       = 32;
  localparam int PRF_NUM_DEFAULT       = 64;
  localparam int CRT_COMMIT_WIDTH      = 2;
  localparam int CRT_RESTORE_PER_CYCLE = 8;

  typedef logic [$clog2(PRF_NUM_DEFAULT)-1:0] prf_specifier_t;
  typedef logic [$clog2(ARF_NUM_DEFAULT)-1:0] arf_specifier_t;

  typedef enum logic {
    RST_IDLE,
    RST_WALK
  } restore_state_e;

endpackage

// File: rtl/crt_bypass_resolve.sv
// rtl/crt_bypass_resolve.sv - per-lane superseded-mapping select with intra-bundle priority
module crt_bypass_resolve #(
  parameter int COMMIT_WIDTH = 2,
  parameter int ARFW         = 5,
  parameter int PRFW         = 6
) (
  input  logic [COMMIT_WIDTH-1:0]      commit_valid,
  input  logic [COMMIT_WIDTH*ARFW-1:0] commit_arf,
  input  logic [COMMIT_WIDTH*PRFW-1:0] commit_prf,
  input  logic [COMMIT_WIDTH*PRFW-1:0] table_prf,
  output logic [COMMIT_WIDTH-1:0]      active,
  output logic [COMMIT_WIDTH*PRFW-1:0] old_prf
);

  always_comb begin
    active  = '0;
    old_prf = table_prf;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      active[k] = commit_valid[k] && (commit_arf[k*ARFW +: ARFW] != '0);
      // Scanning older lanes in age order leaves the youngest matching one in place.
      for (int j = 0; j < k; j++) begin
        if (commit_valid[j] && (commit_arf[j*ARFW +: ARFW] != '0) &&
            (commit_arf[j*ARFW +: ARFW] == commit_arf[k*ARFW +: ARFW])) begin
          old_prf[k*PRFW +: PRFW] = commit_prf[j*PRFW +: PRFW];
        end
      end
    end
  end

endmodule

// File: rtl/committed_rename_table.sv
// rtl/committed_rename_table.sv - committed ARF->PRF map with free-list return and flush restore walk
module committed_rename_table
  import Falco_pkg::*;
#(
  parameter int COMMIT_WIDTH      = CRT_COMMIT_WIDTH,
  parameter int ARF_NUM           = ARF_NUM_DEFAULT,
  parameter int PRF_NUM           = PRF_NUM_DEFAULT,
  parameter int RESTORE_PER_CYCLE = CRT_RESTORE_PER_CYCLE,
  localparam int ARFW  = $clog2(ARF_NUM),
  localparam int PRFW  = $clog2(PRF_NUM),
  localparam int BEATS = ARF_NUM / RESTORE_PER_CYCLE,
  localparam int CNTW  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [COMMIT_WIDTH-1:0]           commit_valid,
  input  logic [COMMIT_WIDTH*ARFW-1:0]      commit_arf,
  input  logic [COMMIT_WIDTH*PRFW-1:0]      commit_prf,
  output logic [COMMIT_WIDTH-1:0]           free_valid,
  output logic [COMMIT_WIDTH*PRFW-1:0]      free_prf,
  input  logic                              restore_req,
  output logic                              restore_busy,
  output logic                              restore_valid,
  output logic [ARFW-1:0]                   restore_base,
  output logic [RESTORE_PER_CYCLE*PRFW-1:0] restore_prf,
  output logic                              restore_done
);

  logic [PRFW-1:0]              map_q [ARF_NUM];
  logic [COMMIT_WIDTH*PRFW-1:0] table_prf;
  logic [COMMIT_WIDTH*PRFW-1:0] old_prf;
  logic [COMMIT_WIDTH-1:0]      active;
  restore_state_e               state_q, state_d;
  logic [CNTW-1:0]              cnt_q, cnt_d;
  logic                         walking, last_beat;

  always_comb begin
    table_prf = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      table_prf[k*PRFW +: PRFW] = map_q[commit_arf[k*ARFW +: ARFW]];
    end
  end

  crt_bypass_resolve #(
    .COMMIT_WIDTH(COMMIT_WIDTH),
    .ARFW        (ARFW),
    .PRFW        (PRFW)
  ) u_bypass (
    .commit_valid(commit_valid),
    .commit_arf  (commit_arf),
    .commit_prf  (commit_prf),
    .table_prf   (table_prf),
    .active      (active),
    .old_prf     (old_prf)
  );

  // Later lanes are assigned last, so the youngest writer of an ARF wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARF_NUM; i++) begin
        map_q[i] <= PRFW'(i);
      end
    end else begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (active[k]) begin
          map_q[commit_arf[k*ARFW +: ARFW]] <= commit_prf[k*PRFW +: PRFW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_valid <= '0;
      free_prf   <= '0;
    end else begin
      free_valid <= active;
      free_prf   <= old_prf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign walking   = (state_q == RST_WALK);
  assign last_beat = (cnt_q == CNTW'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RST_IDLE: begin
        if (restore_req) begin
          state_d = RST_WALK;
          cnt_d   = '0;
        end
      end
      RST_WALK: begin
        if (last_beat) begin
          state_d = RST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RST_IDLE;
    endcase
  end

  assign restore_busy  = walking;
  assign restore_valid = walking;
  assign restore_done  = walking && last_beat;
  assign restore_base  = walking ? ARFW'(32'(cnt_q) * RESTORE_PER_CYCLE) : '0;

  always_comb begin
    restore_prf = '0;
    if (walking) begin
      for (int i = 0; i < RESTORE_PER_CYCLE; i++) begin
        restore_prf[i*PRFW +: PRFW] = map_q[restore_base + ARFW'(i)];
      end
    end
  end

endmodule

// File: tb/tb_committed_rename_table.sv
// tb/tb_committed_rename_table.sv - directed self-checking bench for committed_rename_table
module tb_committed_rename_table;

  logic        clk;
  logic        rst;
  logic [1:0]  commit_valid;
  logic [9:0]  commit_arf;
  logic [11:0] commit_prf;
  logic [1:0]  free_valid;
  logic [11:0] free_prf;
  logic        restore_req;
  logic        restore_busy;
  logic        restore_valid;
  logic [4:0]  restore_base;
  logic [47:0] restore_prf;
  logic        restore_done;

  int          vectors;
  int          miscompares;
  logic [5:0]  exp_map [32];
  logic [5:0]  got_map [32];

  committed_rename_table dut (
    .clk          (clk),
    .rst          (rst),
    .commit_valid (commit_valid),
    .commit_arf   (commit_arf),
    .commit_prf   (commit_prf),
    .free_valid   (free_valid),
    .free_prf     (free_prf),
    .restore_req  (restore_req),
    .restore_busy (restore_busy),
    .restore_valid(restore_valid),
    .restore_base (restore_base),
    .restore_prf  (restore_prf),
    .restore_done (restore_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && restore_busy) check("no_commit_in_walk", 64'(commit_valid), 64'd0);
  end

  task automatic identity_map();
    for (int i = 0; i < 32; i++) exp_map[i] = 6'(i);
  endtask

  task automatic run_restore(input bit with_commit, input bit req_again);
    int beats;
    int dones;
    restore_req = 1'b1;
    if (with_commit) begin
      commit_valid = 2'b01;
      commit_arf   = {5'd0, 5'd9};
      commit_prf   = {6'd0, 6'd60};
    end
    tick();
    restore_req  = 1'b0;
    commit_valid = 2'b00;
    if (with_commit) begin
      check("same_cycle_free_valid", 64'(free_valid), 64'b01);
      check("same_cycle_free_prf0", 64'(free_prf[5:0]), 64'd9);
    end
    beats = 0;
    dones = 0;
    for (int c = 0; c < 12 && restore_busy; c++) begin
      check("restore_valid", 64'(restore_valid), 64'd1);
      check("restore_base", 64'(restore_base), 64'(beats * 8));
      if (restore_done) begin
        dones++;
        check("done_beat", 64'(beats), 64'd3);
      end
      if (beats < 4) begin
        for (int i = 0; i < 8; i++) got_map[beats*8 + i] = restore_prf[i*6 +: 6];
      end
      restore_req = (req_again && beats == 1);
      beats++;
      tick();
    end
    restore_req = 1'b0;
    check("beat_count", 64'(beats), 64'd4);
    check("done_count", 64'(dones), 64'd1);
    check("idle_after_walk", 64'(restore_busy), 64'd0);
    for (int i = 0; i < 32; i++) check($sformatf("map[%0d]", i), 64'(got_map[i]), 64'(exp_map[i]));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    commit_valid = '0;
    commit_arf   = '0;
    commit_prf   = '0;
    restore_req  = 1'b0;
    identity_map();
    tick();
    tick();
    check("rst_free_valid", 64'(free_valid), 64'd0);
    check("rst_free_prf", 64'(free_prf), 64'd0);
    check("rst_busy", 64'(restore_busy), 64'd0);
    check("rst_valid", 64'(restore_valid), 64'd0);
    check("rst_done", 64'(restore_done), 64'd0);
    check("rst_base", 64'(restore_base), 64'd0);
    check("rst_restore_prf", 64'(restore_prf), 64'd0);
    rst = 1'b0;
    tick();
    run_restore(1'b0, 1'b0);

    // Lane0 x5 -> p40.
    commit_valid = 2'b01; commit_arf = {5'd0, 5'd5}; commit_prf = {6'd0, 6'd40};
    tick();
    commit_valid = 2'b00;
    check("x5_free_valid", 64'(free_valid), 64'b01);
    check("x5_free_prf0", 64'(free_prf[5:0]), 64'd5);
    tick();
    check("x5_free_one_cycle", 64'(free_valid), 64'd0);
    exp_map[5] = 6'd40;

    // Both lanes write x7; lane1 sees lane0's p41 as superseded.
    commit_valid = 2'b11; commit_arf = {5'd7, 5'd7}; commit_prf = {6'd42, 6'd41};
    tick();
    commit_valid = 2'b00;
    check("x7_free_valid", 64'(free_valid), 64'b11);
    check("x7_free_prf0", 64'(free_prf[5:0]), 64'd7);
    check("x7_free_prf1", 64'(free_prf[11:6]), 64'd41);
    exp_map[7] = 6'd42;

    // x0 commit is dropped; x3 proceeds.
    commit_valid = 2'b11; commit_arf = {5'd3, 5'd0}; commit_prf = {6'd51, 6'd50};
    tick();
    commit_valid = 2'b00;
    check("x0_free_valid", 64'(free_valid), 64'b10);
    check("x3_free_prf1", 64'(free_prf[11:6]), 64'd3);
    exp_map[3] = 6'd51;
    tick();
    run_restore(1'b0, 1'b0);

    // Commit alongside restore_req, plus an ignored second request mid-walk.
    exp_map[9] = 6'd60;
    run_restore(1'b1, 1'b1);

    // Reset on the second beat of a walk.
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    check("rw_beat1_busy", 64'(restore_busy), 64'd1);
    tick();
    check("rw_beat2_base", 64'(restore_base), 64'd8);
    check("rw_beat2_done", 64'(restore_done), 64'd0);
    rst = 1'b1;
    tick();
    check("rw_busy_after_rst", 64'(restore_busy), 64'd0);
    check("rw_done_after_rst", 64'(restore_done), 64'd0);
    rst = 1'b0;
    tick();
    check("rw_idle_after_rst", 64'(restore_busy), 64'd0);
    check("rw_no_done", 64'(restore_done), 64'd0);
    identity_map();
    run_restore(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
